dot_product_reader: RTL and testbench

//   Read-side controller for the dot-product datapath. Issues sequential reads to two

---
 rtl/dot_product_reader.sv | 119 +++++++++++
 tb/tb_dot_product_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_reader.sv
// Read-side dot-product controller: streams A/B element pairs from two memories and accumulates their products.
// Optional feature macro: DOTP_SIGNED_EN treats operands and result as two's complement (default unsigned).
module dot_product_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH+1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  busy_o,
    output logic [ACC_WIDTH-1:0]  result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEFT = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    result_q, result_d;
    logic                    vld_q;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;

`ifdef DOTP_SIGNED_EN
    assign prod = $signed({{DATA_WIDTH{a_data_i[DATA_WIDTH-1]}}, a_data_i})
                * $signed({{DATA_WIDTH{b_data_i[DATA_WIDTH-1]}}, b_data_i});
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
`else
    assign prod = {{DATA_WIDTH{1'b0}}, a_data_i} * {{DATA_WIDTH{1'b0}}, b_data_i};
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
`endif

    assign rd_en_o        = (state_q == S_READ);
    assign rd_addr_o      = addr_q;
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = (state_q == S_DONE);
    assign result_o       = result_q;

    // Memory data arrives one cycle after each read, so the accumulate runs one cycle behind rd_en.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (vld_q) begin
            acc_d = acc_q + prod_ext;
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        addr_d  = base_addr_i;
                        cnt_d   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                        acc_d   = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == ONE_LEFT) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                result_d = acc_d;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (result_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            vld_q    <= rd_en_o;
        end
    end

endmodule

// File: tb/tb_dot_product_reader.sv
// Scoreboard bench for dot_product_reader: stimulus queues expected reads/results, a negedge monitor checks them.
// Reference results come from plain arithmetic over the bench's own memory arrays (DOTP_SIGNED_EN aware).
module tb_dot_product_reader;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int ACC  = 2*DW+AW+1;
    localparam int NMEM = 1 << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic           startIn;
    logic [AW-1:0]  baseAddr;
    logic [AW:0]    lenIn;
    logic           rdEn;
    logic [AW-1:0]  rdAddr;
    logic [DW-1:0]  aData;
    logic [DW-1:0]  bData;
    logic           busy;
    logic [ACC-1:0] result;
    logic           resultValid;
    logic           resultReady;

    logic [DW-1:0]  memA [NMEM];
    logic [DW-1:0]  memB [NMEM];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } rdExp_t;

    typedef struct {
        logic [ACC-1:0] value;
        int             cyc;
    } resExp_t;

    rdExp_t  addrQ[$];
    resExp_t resQ[$];

    logic           prevValid;
    logic           prevAccept;
    logic [ACC-1:0] heldResult;

    always #5 clk = ~clk;

    dot_product_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ACC_WIDTH (ACC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (startIn),
        .base_addr_i   (baseAddr),
        .len_i         (lenIn),
        .rd_en_o       (rdEn),
        .rd_addr_o     (rdAddr),
        .a_data_i      (aData),
        .b_data_i      (bData),
        .busy_o        (busy),
        .result_o      (result),
        .result_valid_o(resultValid),
        .result_ready_i(resultReady)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read memories; garbage on idle cycles shows whether unqualified data leaks in.
    always @(posedge clk) begin
        if (rdEn) begin
            aData <= memA[rdAddr];
            bData <= memB[rdAddr];
        end else begin
            aData <= DW'($urandom);
            bData <= DW'($urandom);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int elemVal(input logic [DW-1:0] v);
`ifdef DOTP_SIGNED_EN
        return int'($signed(v));
`else
        return int'({24'd0, v});
`endif
    endfunction

    function automatic int clampLen(input int len);
        return (len > NMEM) ? NMEM : len;
    endfunction

    function automatic logic [ACC-1:0] refDot(input int base, input int len);
        int sum = 0;
        for (int i = 0; i < clampLen(len); i++) begin
            int idx = (base + i) % NMEM;
            sum += elemVal(memA[idx]) * elemVal(memB[idx]);
        end
        return ACC'(sum);
    endfunction

    // Monitor: compares every read and every result presentation against the queued expectations.
    always @(negedge clk) begin
        if (rst) begin
            prevValid  <= 1'b0;
            prevAccept <= 1'b0;
        end else begin
            if (rdEn) begin
                if (addrQ.size() == 0) begin
                    checkOutput("unexpected rd_en", 1, 0);
                end else begin
                    checkOutput("rd_addr", 64'(rdAddr), 64'(addrQ[0].addr));
                    checkOutput("rd_en cycle", 64'(cyc), 64'(addrQ[0].cyc));
                    void'(addrQ.pop_front());
                end
            end
            if (resultValid && !prevValid) begin
                if (resQ.size() == 0) begin
                    checkOutput("unexpected result_valid", 1, 0);
                end else begin
                    checkOutput("result", 64'(result), 64'(resQ[0].value));
                    checkOutput("result_valid cycle", 64'(cyc), 64'(resQ[0].cyc));
                    void'(resQ.pop_front());
                end
                heldResult <= result;
            end else if (resultValid) begin
                checkOutput("result stable", 64'(result), 64'(heldResult));
            end
            if (prevAccept) begin
                checkOutput("valid drops after handshake", 64'(resultValid), 0);
            end
            prevValid  <= resultValid;
            prevAccept <= resultValid && resultReady;
        end
    end

    task automatic waitIdle();
        int k = 0;
        while ((busy || resultValid) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) checkOutput("idle timeout", 64'(busy), 0);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NMEM; i++) begin
            memA[i] = DW'($urandom);
            memB[i] = DW'($urandom);
        end
    endtask

    task automatic queueExpect(input int base, input int len, input int t);
        int n = clampLen(len);
        resExp_t r;
        for (int i = 0; i < n; i++) begin
            rdExp_t e;
            e.addr = AW'((base + i) % NMEM);
            e.cyc  = t + i;
            addrQ.push_back(e);
        end
        r.value = refDot(base, len);
        r.cyc   = (n == 0) ? t : t + n + 1;
        resQ.push_back(r);
    endtask

    // One full request: start, wait for the result, optionally stall ready and poke start while DONE.
    task automatic applyStimulus(input int base, input int len, input int holdCycles, input bit pulseStart);
        int k = 0;
        waitIdle();
        queueExpect(base, len, cyc + 1);
        resultReady = (holdCycles == 0);
        startIn  = 1'b1;
        baseAddr = AW'(base);
        lenIn    = (AW+1)'(len);
        @(posedge clk);
        #1;
        startIn = 1'b0;
        while (!resultValid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 100) checkOutput("result_valid timeout", 64'(resultValid), 1);
        if (holdCycles > 0) begin
            for (int h = 0; h < holdCycles; h++) begin
                if (pulseStart && h == 1) begin
                    startIn  = 1'b1;
                    baseAddr = AW'($urandom);
                    lenIn    = 5;
                end
                @(posedge clk);
                #1;
                startIn = 1'b0;
            end
            resultReady = 1'b1;
            startIn     = pulseStart;
            @(posedge clk);
            #1;
            startIn = 1'b0;
        end
        resultReady = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rd_en"}, 64'(rdEn), 0);
        checkOutput({tag, " rd_addr"}, 64'(rdAddr), 0);
        checkOutput({tag, " busy"}, 64'(busy), 0);
        checkOutput({tag, " result_valid"}, 64'(resultValid), 0);
        checkOutput({tag, " result"}, 64'(result), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        startIn     = 1'b0;
        baseAddr    = '0;
        lenIn       = '0;
        resultReady = 1'b1;
        fillRandom();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NMEM; i++) begin
            memA[i] = DW'(i + 1);
            memB[i] = DW'(i + 5);
        end
        applyStimulus(0, 4, 0, 1'b0);

        fillRandom();
        applyStimulus(14, 4, 0, 1'b0);
        applyStimulus(5, 0, 0, 1'b0);
        applyStimulus(3, 6, 5, 1'b1);
        applyStimulus(7, 25, 0, 1'b0);

        for (int i = 0; i < NMEM; i++) begin
            memA[i] = 8'hFF;
            memB[i] = 8'hFF;
        end
        applyStimulus(0, 16, 0, 1'b0);
        memA[9] = 8'h80;
        memB[9] = 8'h7F;
        applyStimulus(9, 1, 0, 1'b0);

        // Abort a long read mid-stream; nothing of that request may surface afterwards.
        waitIdle();
        fillRandom();
        queueExpect(2, 12, cyc + 1);
        startIn  = 1'b1;
        baseAddr = 4'd2;
        lenIn    = 5'd12;
        @(posedge clk);
        #1;
        startIn = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("abort");
        addrQ.delete();
        resQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("abort no result_valid", 64'(resultValid), 0);
        checkOutput("abort idle", 64'(busy), 0);

        for (int t = 0; t < 25; t++) begin
            int hold;
            fillRandom();
            hold = $urandom_range(0, 3);
            applyStimulus($urandom_range(0, NMEM-1), $urandom_range(0, 31), hold, 1'($urandom_range(0, 1)));
        end

        waitIdle();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("read queue drained", 64'(addrQ.size()), 0);
        checkOutput("result queue drained", 64'(resQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
